// File: rtl/uart_rx_parity.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_parity
// Purpose  : 8E1 serial receiver (8 data bits LSB first, even parity, one
//            stop bit). Oversamples rx at CLKS_PER_BIT clocks per bit and
//            delivers each recovered byte with parity and framing status.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous active-high reset
//            rx         - asynchronous serial line, idle high
//            data       - last received byte, updated with valid
//            valid      - one-cycle pulse per completed frame
//            parity_err - last frame: XOR of data bits and parity bit is 1
//            frame_err  - last frame: stop bit sampled low
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_parity #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  logic [1:0]       sync;
  logic             rxs;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             par_bit;
  logic             stop_bit;
  logic             done;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rxs = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      stop_bit   <= 1'b1;
      done       <= 1'b0;
      data       <= 8'h00;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end

        // Re-check the line at mid start bit to reject short glitches.
        START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            idx   <= 3'd0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            if (idx == 3'd7) begin
              state <= PARITY;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= rxs;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // The stop bit is sampled first; results are published on the
        // following cycle. A start bit already present on that cycle is
        // taken directly so back-to-back frames are not lost.
        STOP: begin
          if (done) begin
            done       <= 1'b0;
            valid      <= 1'b1;
            data       <= shreg;
            parity_err <= ^{shreg, par_bit};
            frame_err  <= ~stop_bit;
            if (!stop_bit) begin
              state <= BREAK;
            end else if (!rxs) begin
              state <= START;
              cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (cnt == CNT_LAST) begin
            cnt      <= '0;
            stop_bit <= rxs;
            done     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Line held low after a bad stop bit: wait for it to return high
        // so the low level is not mistaken for a new start bit.
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_parity.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_parity
// Purpose  : Self-checking bench for uart_rx_parity at 16 clocks per bit.
//            Expected frames are queued as they are transmitted; a monitor
//            queues every valid pulse, and each scenario task pops and
//            compares the two.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_parity;

  localparam int CPB     = 16;
  localparam int LAT_PIN = 172;  // tx start negedge to valid-sampling negedge

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  rec_t exp_q[$];
  rec_t obs_q[$];

  uart_rx_parity #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      obs_q.push_back('{d: data, pe: parity_err, fe: frame_err, cyc: cyc});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    rec_t e;
    e.d   = d;
    e.pe  = (^d) ^ par;
    e.fe  = ~stop;
    e.cyc = cyc + LAT_PIN;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic test_reset();
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks += 4;
    if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b expected 0", parity_err); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    repeat (500) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d valid pulses expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_good_frame();
    rec_t e, o;
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL good_valid: got no valid expected data %h", e.d);
      end else begin
        o = obs_q.pop_front();
        n_checks += 3;
        if (o.d !== e.d) begin n_fail++; $display("FAIL good_data: got %h expected %h", o.d, e.d); end
        if (o.pe !== e.pe || o.fe !== e.fe) begin n_fail++; $display("FAIL good_flags: got pe=%b fe=%b expected pe=%b fe=%b", o.pe, o.fe, e.pe, e.fe); end
        if (o.cyc != e.cyc) begin n_fail++; $display("FAIL good_latency: got cycle %0d expected %0d", o.cyc, e.cyc); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL good_extra: got %0d extra valid expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_parity();
    rec_t e, o;
    send_frame(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL parity_valid: got no valid expected data %h", e.d);
      end else begin
        o = obs_q.pop_front();
        n_checks += 3;
        if (o.d !== e.d) begin n_fail++; $display("FAIL parity_data: got %h expected %h", o.d, e.d); end
        if (o.pe !== e.pe) begin n_fail++; $display("FAIL parity_perr: got %b expected %b", o.pe, e.pe); end
        if (o.fe !== e.fe) begin n_fail++; $display("FAIL parity_ferr: got %b expected %b", o.fe, e.fe); end
      end
    end
    n_checks++;
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_hold: got %b expected 0", parity_err); end
    obs_q.delete();
  endtask

  task automatic test_frame_error();
    rec_t e, o;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL ferr_count: got %0d valid pulses expected 1", obs_q.size()); end
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_hold: got %b expected 1", frame_err); end
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL ferr_valid: got no valid expected data %h", e.d);
      end else begin
        o = obs_q.pop_front();
        n_checks += 3;
        if (o.d !== e.d) begin n_fail++; $display("FAIL ferr_data: got %h expected %h", o.d, e.d); end
        if (o.pe !== e.pe || o.fe !== e.fe) begin n_fail++; $display("FAIL ferr_flags: got pe=%b fe=%b expected pe=%b fe=%b", o.pe, o.fe, e.pe, e.fe); end
        if (o.cyc != e.cyc) begin n_fail++; $display("FAIL ferr_latency: got cycle %0d expected %0d", o.cyc, e.cyc); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL ferr_extra: got %0d extra valid expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_glitch_reset();
    rec_t e, o;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_valid: got %0d valid pulses expected 0", obs_q.size()); end
    // Start 0xFF and reset in the middle of data bit 3; the sender then abandons it.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks += 4;
    if (data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", data); end
    if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", valid); end
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL midrst_perr: got %b expected 0", parity_err); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_ferr: got %b expected 0", frame_err); end
    repeat (300) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_nvalid: got %0d valid pulses expected 0", obs_q.size()); end
    obs_q.delete();
    send_frame(8'h81, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL after_rst_valid: got no valid expected data %h", e.d);
      end else begin
        o = obs_q.pop_front();
        n_checks += 3;
        if (o.d !== e.d) begin n_fail++; $display("FAIL after_rst_data: got %h expected %h", o.d, e.d); end
        if (o.pe !== e.pe || o.fe !== e.fe) begin n_fail++; $display("FAIL after_rst_flags: got pe=%b fe=%b expected pe=%b fe=%b", o.pe, o.fe, e.pe, e.fe); end
        if (o.cyc != e.cyc) begin n_fail++; $display("FAIL after_rst_latency: got cycle %0d expected %0d", o.cyc, e.cyc); end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    int   prev_cyc;
    prev_cyc = -1;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d valid pulses expected 3", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) begin
        o = obs_q.pop_front();
        n_checks += 3;
        if (o.d !== e.d) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", o.d, e.d); end
        if (o.pe !== 1'b0 || o.fe !== 1'b0) begin n_fail++; $display("FAIL b2b_flags: got pe=%b fe=%b expected pe=0 fe=0", o.pe, o.fe); end
        if (o.cyc != e.cyc) begin n_fail++; $display("FAIL b2b_latency: got cycle %0d expected %0d", o.cyc, e.cyc); end
        if (prev_cyc >= 0) begin
          n_checks++;
          if (o.cyc - prev_cyc != 11 * CPB) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles expected %0d", o.cyc - prev_cyc, 11 * CPB);
          end
        end
        prev_cyc = o.cyc;
      end
    end
    obs_q.delete();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_parity();
    test_frame_error();
    test_glitch_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
